// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array result drain.
// Build option: SA_DRAIN_TRANSPOSE_EN (column-per-beat read-out, see sa_snapshot_buf).
package sa_pkg;

  localparam int N     = 8;           // array dimension (rows = cols)
  localparam int DW    = 16;          // width of one result word
  localparam int IDXW  = $clog2(N);   // beat index width
  localparam int FLATW = N * N * DW;  // flattened tile width
  localparam int ROWW  = N * DW;      // one beat

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    STREAM = 2'd2
  } state_e;

  // Bit offset of Y_rc inside the flattened tile vector.
  function automatic int unsigned y_off(input int unsigned r, input int unsigned c);
    return ((r * N) + c) * DW;
  endfunction

endpackage

// File: rtl/sa_snapshot_buf.sv
// N*N*DW capture register with an N-way beat-select read port.
// Build option: SA_DRAIN_TRANSPOSE_EN selects column k instead of row k;
// only the read mux changes, the stored image is identical.
module sa_snapshot_buf
  import sa_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic [FLATW-1:0] y_flat,
  input  logic [IDXW-1:0] sel,
  output logic [ROWW-1:0] data_out
);

  logic [FLATW-1:0] snap_q;
  logic [FLATW-1:0] snap_d;

  // Capture the whole tile only on the load strobe, otherwise hold
  always_comb begin
    if (load) begin
      snap_d = y_flat;
    end else begin
      snap_d = snap_q;
    end
  end

  // Snapshot storage, cleared on reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q <= {FLATW{1'b0}};
    end else begin
      snap_q <= snap_d;
    end
  end

  // Beat read mux: row sel (default) or column sel (transposed build)
  always_comb begin
    data_out = {ROWW{1'b0}};
    for (int unsigned i = 0; i < N; i++) begin
`ifdef SA_DRAIN_TRANSPOSE_EN
      data_out[i*DW +: DW] = snap_q[y_off(i, 32'(sel)) +: DW];
`else
      data_out[i*DW +: DW] = snap_q[y_off(32'(sel), i) +: DW];
`endif
    end
  end

endmodule

// File: rtl/sa_result_drain.sv
// Result drain for the 8x8 systolic tile: waits LATENCY cycles after START,
// snapshots all accumulator outputs, then streams one row per VALID/READY beat.
// Build option: SA_DRAIN_TRANSPOSE_EN streams columns instead of rows.
module sa_result_drain
  import sa_pkg::*;
#(
  parameter int LATENCY = 22
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                START,
  input  logic [N*N*DW-1:0]   Y_FLAT,
  output logic                BUSY,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [N*DW-1:0]     OUT_DATA,
  output logic [IDXW-1:0]     OUT_ROW,
  output logic                OUT_LAST,
  output logic                DONE
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [7:0]      CNT_LOAD = 8'(LATENCY - 1);

  state_e          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            valid_q, valid_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            xfer_s;
  logic            load_s;

  // Next-state, wait counter and beat handshake; READY only affects the next edge
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load_s  = 1'b0;
    xfer_s  = valid_q & OUT_READY;
    case (state_q)
      IDLE: begin
        if (START) begin
          state_d = WAIT;
          cnt_d   = CNT_LOAD;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 8'd0) begin
          load_s  = 1'b1;
          state_d = STREAM;
          idx_d   = {IDXW{1'b0}};
          valid_d = 1'b1;
          last_d  = (LAST_IDX == {IDXW{1'b0}});
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      STREAM: begin
        if (xfer_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = {IDXW{1'b0}};
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d  = idx_q + IDXW'(1'b1);
            last_d = ((idx_q + IDXW'(1'b1)) == LAST_IDX);
          end
        end else begin
          idx_d = idx_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        idx_d   = {IDXW{1'b0}};
        valid_d = 1'b0;
        last_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control state and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= {IDXW{1'b0}};
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  sa_snapshot_buf u_snap (
    .clk      (CLK),
    .rst_n    (RST_N),
    .load     (load_s),
    .y_flat   (Y_FLAT),
    .sel      (idx_q),
    .data_out (OUT_DATA)
  );

  assign BUSY      = busy_q;
  assign OUT_VALID = valid_q;
  assign OUT_ROW   = idx_q;
  assign OUT_LAST  = last_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_sa_result_drain.sv
// Self-checking bench for sa_result_drain: a transaction-level model of the
// drain (snapshot matrix + beat index) checked every cycle, plus literal checks.
module tb_sa_result_drain;
  import sa_pkg::*;

  localparam int LAT = 22;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              START = 1'b0;
  logic              OUT_READY = 1'b0;
  logic [N*N*DW-1:0] y_flat;
  logic              BUSY, OUT_VALID, OUT_LAST, DONE;
  logic [N*DW-1:0]   OUT_DATA;
  logic [IDXW-1:0]   OUT_ROW;

  logic [DW-1:0] y_mat [N][N];

  int vec_n = 0;
  int err_n = 0;

  sa_result_drain #(.LATENCY(LAT)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .Y_FLAT(y_flat),
    .BUSY(BUSY), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUT_DATA(OUT_DATA), .OUT_ROW(OUT_ROW), .OUT_LAST(OUT_LAST), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Pack the bench matrix: Y_rc at bits ((r*N)+c)*DW
  always_comb begin
    y_flat = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        y_flat[((r*N)+c)*DW +: DW] = y_mat[r][c];
  end

  // ---------------- behavioural model ----------------
  bit            m_busy, m_valid, m_done;
  int            m_wait, m_beat;
  logic [DW-1:0] m_snap [N][N];
  int            log_n = 0;
  int            done_seen = 0;
  logic [N*DW-1:0] log_data [64];
  int            log_row [64];
  logic          log_last [64];

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_done <= 1'b0; m_wait <= 0; m_beat <= 0;
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++)
          m_snap[r][c] <= '0;
    end else begin
      m_done <= 1'b0;
      if (OUT_VALID && OUT_READY && log_n < 64) begin
        log_data[log_n] <= OUT_DATA;
        log_row[log_n]  <= int'(OUT_ROW);
        log_last[log_n] <= OUT_LAST;
        log_n           <= log_n + 1;
      end
      if (DONE) done_seen <= done_seen + 1;
      if (!m_busy) begin
        if (START) begin
          m_busy <= 1'b1;
          m_wait <= LAT;
        end
      end else if (m_wait > 0) begin
        if (m_wait == 1) begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              m_snap[r][c] <= y_mat[r][c];
          m_valid <= 1'b1;
          m_beat  <= 0;
        end
        m_wait <= m_wait - 1;
      end else if (OUT_READY) begin
        if (m_beat == N-1) begin
          m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b1; m_beat <= 0;
        end else begin
          m_beat <= m_beat + 1;
        end
      end
    end
  end

  function automatic logic [N*DW-1:0] exp_beat(input int k);
    logic [N*DW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
`ifdef SA_DRAIN_TRANSPOSE_EN
      v[i*DW +: DW] = m_snap[i][k];
`else
      v[i*DW +: DW] = m_snap[k][i];
`endif
    end
    return v;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, away from the rising edge
  initial begin
    forever begin
      @(negedge CLK);
      #1;
      chk("busy", 128'(BUSY), 128'(m_busy));
      chk("valid", 128'(OUT_VALID), 128'(m_valid));
      chk("done", 128'(DONE), 128'(m_done));
      if (m_valid) begin
        chk("data", 128'(OUT_DATA), 128'(exp_beat(m_beat)));
        chk("row", 128'(OUT_ROW), 128'(m_beat));
        chk("last", 128'(OUT_LAST), 128'(m_beat == N-1));
      end
      if (!RST_N) chk("rst_data", 128'(OUT_DATA), 128'(0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic set_pattern();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        y_mat[r][c] = 16'(r*16 + c);
  endtask

  task automatic start_pulse();
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    while (!OUT_VALID && k < 300) begin
      @(negedge CLK);
      k++;
    end
  endtask

  task automatic wait_done(inout int k);
    while (!DONE && k < 300) begin
      @(negedge CLK);
      k++;
    end
  endtask

  logic [DW-1:0] w35_exp, w70_exp;
  int kv, kd, base, dbase;
  int stall [N];

  initial begin
`ifdef SA_DRAIN_TRANSPOSE_EN
    w35_exp = 16'h0053;
    w70_exp = 16'h0007;
`else
    w35_exp = 16'h0035;
    w70_exp = 16'h0070;
`endif
    set_pattern();

    // Reset held with START toggling
    for (int i = 0; i < 6; i++) begin
      START = ~START;
      @(negedge CLK);
    end
    START = 1'b0;
    chk("reset_busy", 128'(BUSY), 128'(0));
    chk("reset_valid", 128'(OUT_VALID), 128'(0));
    chk("reset_data", 128'(OUT_DATA), 128'(0));
    chk("reset_done", 128'(DONE), 128'(0));
    RST_N = 1'b1;
    tick(3);

    // Basic drain, READY high throughout
    OUT_READY = 1'b1;
    base = log_n; dbase = done_seen;
    start_pulse();
    wait_valid(kv);
    chk("basic_valid_latency", 128'(kv), 128'(LAT));
    kd = kv;
    wait_done(kd);
    chk("basic_done_cycle", 128'(kd), 128'(LAT + N));
    chk("basic_busy_fall", 128'(BUSY), 128'(0));
    tick(1);
    chk("basic_beats", 128'(log_n - base), 128'(N));
    chk("basic_done_count", 128'(done_seen - dbase), 128'(1));
    chk("basic_b0w0", 128'(log_data[base][0 +: DW]), 128'(16'h0000));
    chk("basic_b3w5", 128'(log_data[base+3][5*DW +: DW]), 128'(w35_exp));
    chk("basic_b7w0", 128'(log_data[base+7][0 +: DW]), 128'(w70_exp));
    chk("basic_row7", 128'(log_row[base+7]), 128'(7));
    chk("basic_last6", 128'(log_last[base+6]), 128'(0));
    chk("basic_last7", 128'(log_last[base+7]), 128'(1));
    tick(2);

    // Backpressure on beats 3..5, four cycles each
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        y_mat[r][c] = 16'hA500 ^ 16'(r*16 + c);
    for (int i = 0; i < N; i++) stall[i] = 0;
    base = log_n; dbase = done_seen;
    start_pulse();
    wait_valid(kv);
    chk("bp_valid_latency", 128'(kv), 128'(LAT));
    kd = 0;
    while (!DONE && kd < 300) begin
      if (OUT_VALID && int'(OUT_ROW) >= 3 && int'(OUT_ROW) <= 5 && stall[OUT_ROW] < 4) begin
        OUT_READY = 1'b0;
        stall[OUT_ROW]++;
      end else begin
        OUT_READY = 1'b1;
      end
      @(negedge CLK);
      kd++;
    end
    OUT_READY = 1'b1;
    chk("bp_done_cycle", 128'(kd), 128'(N + 12));
    tick(1);
    chk("bp_beats", 128'(log_n - base), 128'(N));
    chk("bp_done_count", 128'(done_seen - dbase), 128'(1));
    for (int i = 0; i < N; i++) chk("bp_order", 128'(log_row[base+i]), 128'(i));
    tick(2);

    // Snapshot isolation: tile goes all-ones right after the snapshot
    set_pattern();
    base = log_n;
    start_pulse();
    wait_valid(kv);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        y_mat[r][c] = 16'hFFFF;
    kd = 0;
    wait_done(kd);
    tick(1);
    chk("iso_beats", 128'(log_n - base), 128'(N));
    chk("iso_b7w7", 128'(log_data[base+7][7*DW +: DW]), 128'(16'h0077));
    chk("iso_b3w5", 128'(log_data[base+3][5*DW +: DW]), 128'(w35_exp));
    set_pattern();
    tick(2);

    // START while busy is ignored
    base = log_n; dbase = done_seen;
    start_pulse();
    tick(5);
    start_pulse();
    wait_valid(kv);
    chk("ign_valid_latency", 128'(kv + 6), 128'(LAT));
    tick(2);
    start_pulse();
    kd = 0;
    wait_done(kd);
    tick(1);
    chk("ign_beats", 128'(log_n - base), 128'(N));
    chk("ign_done_count", 128'(done_seen - dbase), 128'(1));
    chk("ign_idle", 128'(BUSY), 128'(0));
    tick(3);

    // Abort at beat 4 with reset, then a clean drain
    dbase = done_seen;
    start_pulse();
    wait_valid(kv);
    kd = 0;
    while (!(OUT_VALID && OUT_ROW == 3'd4) && kd < 50) begin
      @(negedge CLK);
      kd++;
    end
    chk("abort_reach_b4", 128'(kd), 128'(4));
    RST_N = 1'b0;
    #1;
    chk("abort_valid", 128'(OUT_VALID), 128'(0));
    chk("abort_busy", 128'(BUSY), 128'(0));
    tick(2);
    RST_N = 1'b1;
    tick(3);
    chk("abort_no_done", 128'(done_seen - dbase), 128'(0));
    base = log_n; dbase = done_seen;
    start_pulse();
    wait_valid(kv);
    chk("clean_valid_latency", 128'(kv), 128'(LAT));
    kd = kv;
    wait_done(kd);
    chk("clean_done_cycle", 128'(kd), 128'(LAT + N));
    tick(1);
    chk("clean_beats", 128'(log_n - base), 128'(N));
    chk("clean_done_count", 128'(done_seen - dbase), 128'(1));
    chk("clean_b3w5", 128'(log_data[base+3][5*DW +: DW]), 128'(w35_exp));
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end

endmodule
